fetch_unit: RTL and testbench

Parametrised instruction-fetch front end that replaces the free-running program counter. It holds the PC, issues request/acknowledge fetches to instruction memory, and buffers one fetched instruction behind a valid/ready handshake to the decoder. It also accepts branch/jump redirects from the execute stage and traps misaligned targets. It sits between the instruction ROM and the instruction decoder.

---
 rtl/fetch_unit.sv | 88 ++++++++
 tb/tb_fetch_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, req/ack fetch to imem, one-entry buffer to the decoder.
// Latency: ack in cycle N -> inst_valid in N+1; redirect in N -> pc=target in N+1.
// Backpressure: inst_valid && !inst_ready drops imem_req and holds pc and the buffer.
module fetch_unit #(
    parameter int                ADDR_W     = 8,
    parameter int                INST_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_data,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic [ADDR_W-1:0] pc,
    output logic              misalign
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] inst_pc_nxt;
    logic [INST_W-1:0] inst_data_nxt;
    logic              inst_valid_nxt;
    logic              misalign_nxt;

    // A redirect suppresses the request so a same-cycle ack can never land in the buffer.
    assign imem_req  = (state == RUN) && !reset && !redirect_valid && (!inst_valid || inst_ready);
    assign imem_addr = pc;

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        inst_valid_nxt = inst_valid;
        inst_data_nxt  = inst_data;
        inst_pc_nxt    = inst_pc;
        misalign_nxt   = misalign;
        if (state == RUN) begin
            if (redirect_valid) begin
                // Buffered instruction is flushed even if the decoder is ready this cycle.
                pc_nxt         = redirect_target;
                inst_valid_nxt = 1'b0;
                if (redirect_target[1:0] != 2'b00) begin
                    state_nxt    = HALT;
                    misalign_nxt = 1'b1;
                end
            end else if (imem_req && imem_ack) begin
                inst_data_nxt  = imem_data;
                inst_pc_nxt    = pc;
                inst_valid_nxt = 1'b1;
                pc_nxt         = pc + ADDR_W'(4);
            end else if (inst_valid && inst_ready) begin
                inst_valid_nxt = 1'b0;
            end
        end else begin
            inst_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            pc         <= RESET_ADDR;
            inst_valid <= 1'b0;
            inst_data  <= '0;
            inst_pc    <= '0;
            misalign   <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            inst_valid <= inst_valid_nxt;
            inst_data  <= inst_data_nxt;
            inst_pc    <= inst_pc_nxt;
            misalign   <= misalign_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table for the fetch/backpressure/redirect/trap cases,
// then randomized traffic against a cycle-level reference model.
module tb_fetch_unit;

    logic       clk;
    logic       reset;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [31:0] imem_data;
    logic       inst_valid;
    logic [31:0] inst_data;
    logic [7:0] inst_pc;
    logic       inst_ready;
    logic       redirect_valid;
    logic [7:0] redirect_target;
    logic [7:0] pc;
    logic       misalign;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_unit #(.ADDR_W(8), .INST_W(32), .RESET_ADDR(8'h00)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc), .inst_ready(inst_ready),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .pc(pc), .misalign(misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction ROM: the four program words from the test plan, a hash of the address elsewhere.
    function automatic logic [31:0] rom(input logic [7:0] a);
        case (a)
            8'h00:   rom = 32'h00450693;
            8'h04:   rom = 32'h00100713;
            8'h08:   rom = 32'h00b76463;
            8'h0C:   rom = 32'h00008067;
            default: rom = {a, ~a, a ^ 8'h5A, 8'hC3};
        endcase
    endfunction

    assign imem_data = rom(imem_addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the front end should look like after each clock.
    logic       m_known = 1'b0;
    logic       m_halt  = 1'b0;
    logic       m_valid = 1'b0;
    logic [7:0] m_pc    = 8'h00;
    logic [7:0] m_ipc   = 8'h00;
    logic [31:0] m_data = 32'h0;
    logic       m_mis   = 1'b0;
    logic       obs_req;

    task automatic cycle(input logic r, input logic a, input logic rd, input logic rv,
                         input logic [7:0] t);
        logic exp_req;
        reset = r; imem_ack = a; inst_ready = rd; redirect_valid = rv; redirect_target = t;
        #1;
        exp_req = !m_halt && !r && !rv && (!m_valid || rd);
        chk("imem_req", 64'(imem_req), 64'(exp_req));
        if (m_known) chk("imem_addr", 64'(imem_addr), 64'(m_pc));
        obs_req = imem_req;
        if (r) begin
            m_known = 1'b1; m_halt = 1'b0; m_valid = 1'b0; m_pc = 8'h00;
            m_ipc = 8'h00; m_data = 32'h0; m_mis = 1'b0;
        end else if (m_halt) begin
            m_valid = 1'b0;
        end else if (rv) begin
            m_valid = 1'b0;
            m_pc = t;
            if (t % 4 != 0) begin
                m_halt = 1'b1;
                m_mis  = 1'b1;
            end
        end else if (exp_req && a) begin
            m_ipc = m_pc; m_data = rom(m_pc); m_valid = 1'b1; m_pc = m_pc + 8'd4;
        end else if (m_valid && rd) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        if (m_known) begin
            chk("pc", 64'(pc), 64'(m_pc));
            chk("inst_valid", 64'(inst_valid), 64'(m_valid));
            chk("inst_pc", 64'(inst_pc), 64'(m_ipc));
            chk("inst_data", 64'(inst_data), 64'(m_data));
            chk("misalign", 64'(misalign), 64'(m_mis));
        end
    endtask

    typedef struct {
        logic       rst, ack, rdy, rv;
        logic [7:0] tgt;
        logic       e_req;
        logic [7:0] e_pc;
        logic       e_v;
        logic [7:0] e_ipc;
        logic       e_mis;
    } vec_t;

    vec_t vecs[23];

    initial begin
        reset = 1'b1; imem_ack = 1'b0; inst_ready = 1'b0;
        redirect_valid = 1'b0; redirect_target = 8'h00;

        //          rst  ack  rdy  rv   tgt    req  pc     v    ipc    mis
        vecs[0]  = '{1'b1,1'b1,1'b1,1'b0,8'h00, 1'b0,8'h00, 1'b0,8'h00, 1'b0};
        vecs[1]  = '{1'b0,1'b1,1'b1,1'b0,8'h00, 1'b1,8'h04, 1'b1,8'h00, 1'b0};
        vecs[2]  = '{1'b0,1'b1,1'b1,1'b0,8'h00, 1'b1,8'h08, 1'b1,8'h04, 1'b0};
        vecs[3]  = '{1'b0,1'b1,1'b1,1'b0,8'h00, 1'b1,8'h0C, 1'b1,8'h08, 1'b0};
        vecs[4]  = '{1'b0,1'b1,1'b0,1'b0,8'h00, 1'b0,8'h0C, 1'b1,8'h08, 1'b0};
        vecs[5]  = '{1'b0,1'b1,1'b0,1'b0,8'h00, 1'b0,8'h0C, 1'b1,8'h08, 1'b0};
        vecs[6]  = '{1'b0,1'b1,1'b0,1'b0,8'h00, 1'b0,8'h0C, 1'b1,8'h08, 1'b0};
        vecs[7]  = '{1'b0,1'b1,1'b1,1'b0,8'h00, 1'b1,8'h10, 1'b1,8'h0C, 1'b0};
        vecs[8]  = '{1'b0,1'b0,1'b1,1'b0,8'h00, 1'b1,8'h10, 1'b0,8'h0C, 1'b0};
        vecs[9]  = '{1'b0,1'b0,1'b1,1'b0,8'h00, 1'b1,8'h10, 1'b0,8'h0C, 1'b0};
        vecs[10] = '{1'b0,1'b1,1'b1,1'b0,8'h00, 1'b1,8'h14, 1'b1,8'h10, 1'b0};
        vecs[11] = '{1'b0,1'b1,1'b1,1'b0,8'h00, 1'b1,8'h18, 1'b1,8'h14, 1'b0};
        vecs[12] = '{1'b0,1'b1,1'b1,1'b1,8'h48, 1'b0,8'h48, 1'b0,8'h14, 1'b0};
        vecs[13] = '{1'b0,1'b1,1'b1,1'b0,8'h00, 1'b1,8'h4C, 1'b1,8'h48, 1'b0};
        vecs[14] = '{1'b0,1'b1,1'b1,1'b1,8'h1E, 1'b0,8'h1E, 1'b0,8'h48, 1'b1};
        vecs[15] = '{1'b0,1'b1,1'b1,1'b0,8'h00, 1'b0,8'h1E, 1'b0,8'h48, 1'b1};
        vecs[16] = '{1'b0,1'b1,1'b1,1'b1,8'h00, 1'b0,8'h1E, 1'b0,8'h48, 1'b1};
        vecs[17] = '{1'b1,1'b1,1'b1,1'b0,8'h00, 1'b0,8'h00, 1'b0,8'h00, 1'b0};
        vecs[18] = '{1'b0,1'b1,1'b1,1'b1,8'hFC, 1'b0,8'hFC, 1'b0,8'h00, 1'b0};
        vecs[19] = '{1'b0,1'b1,1'b1,1'b0,8'h00, 1'b1,8'h00, 1'b1,8'hFC, 1'b0};
        vecs[20] = '{1'b0,1'b1,1'b1,1'b0,8'h00, 1'b1,8'h04, 1'b1,8'h00, 1'b0};
        vecs[21] = '{1'b1,1'b1,1'b1,1'b0,8'h00, 1'b0,8'h00, 1'b0,8'h00, 1'b0};
        vecs[22] = '{1'b0,1'b0,1'b0,1'b0,8'h00, 1'b1,8'h00, 1'b0,8'h00, 1'b0};

        for (int i = 0; i < 23; i++) begin
            cycle(vecs[i].rst, vecs[i].ack, vecs[i].rdy, vecs[i].rv, vecs[i].tgt);
            chk($sformatf("tbl%0d_req", i), 64'(obs_req), 64'(vecs[i].e_req));
            chk($sformatf("tbl%0d_pc", i), 64'(pc), 64'(vecs[i].e_pc));
            chk($sformatf("tbl%0d_valid", i), 64'(inst_valid), 64'(vecs[i].e_v));
            chk($sformatf("tbl%0d_ipc", i), 64'(inst_pc), 64'(vecs[i].e_ipc));
            chk($sformatf("tbl%0d_mis", i), 64'(misalign), 64'(vecs[i].e_mis));
            if (vecs[i].e_v)
                chk($sformatf("tbl%0d_data", i), 64'(inst_data), 64'(rom(vecs[i].e_ipc)));
        end

        // Backpressure hold: buffer contents must not move while the decoder stalls.
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            chk("stall_ipc", 64'(inst_pc), 64'(8'h00));
            chk("stall_data", 64'(inst_data), 64'(32'h00450693));
        end

        // Randomized traffic with occasional redirects, misaligned traps and resets.
        for (int n = 0; n < 3000; n++) begin
            logic       r, a, rd, rv;
            logic [7:0] t;
            r  = ($urandom_range(0, 59) == 0);
            a  = ($urandom_range(0, 1) == 1);
            rd = ($urandom_range(0, 9) < 7);
            rv = ($urandom_range(0, 15) == 0);
            t  = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            cycle(r, a, rd, rv, t);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
